// File: rtl/instruction_loader.sv
// instruction_loader: receives a framed program image as a byte stream
// (A5, 16-bit LE word count, 4*N data bytes, 8-bit additive checksum),
// assembles little-endian words and strobes them into the instruction
// memory while holding the CPU in reset.
// Optional feature: define LOADER_TIMEOUT_EN to abort a stalled frame after
// TIMEOUT idle cycles.
module instruction_loader #(
  parameter int bus     = 32,
  parameter int memsize = 4096,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           mem_we,
  output logic [bus-1:0] mem_addr,
  output logic [bus-1:0] mem_wdata,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_error
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR} state_t;

  state_t         state, state_d;
  logic [7:0]     len_lo, len_lo_d;
  logic [15:0]    n_words, n_words_d;
  logic [15:0]    word_idx, word_idx_d;
  logic [1:0]     lane, lane_d;
  logic [23:0]    asm_q, asm_d;
  logic [7:0]     checksum, checksum_d;
  logic           mem_we_d, cpu_hold_d, load_done_d, load_error_d;
  logic [bus-1:0] mem_addr_d, mem_wdata_d;
  logic           accept;
  logic [15:0]    len_full;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0]    idle_cnt, idle_cnt_d;
`else
  // No idle counter: the loader waits indefinitely for the next byte.
`endif

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo};

  // Next-state and next-output decode for every registered output.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    state_d      = state;
    len_lo_d     = len_lo;
    n_words_d    = n_words;
    word_idx_d   = word_idx;
    lane_d       = lane;
    asm_d        = asm_q;
    checksum_d   = checksum;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_hold_d   = cpu_hold;
    load_done_d  = load_done;
    load_error_d = load_error;

    case (state)
      IDLE, DONE, ERROR: begin
        if (accept && in_data == 8'hA5) begin
          state_d      = LEN0;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          checksum_d   = 8'h00;
          word_idx_d   = 16'd0;
          lane_d       = 2'd0;
        end
      end
      LEN0: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          n_words_d = len_full;
          if (32'(len_full) > memsize) begin
            state_d      = ERROR;
            load_error_d = 1'b1;
            cpu_hold_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          checksum_d = checksum + in_data;
          lane_d     = lane + 2'd1;
          case (lane)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = bus'({in_data, asm_q});
              mem_addr_d  = bus'({word_idx, 2'b00});
              word_idx_d  = word_idx + 16'd1;
              if (word_idx == n_words - 16'd1) state_d = CHECK;
            end
          endcase
        end
      end
      CHECK: begin
        if (accept) begin
          if (in_data == checksum) begin
            state_d     = DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d      = ERROR;
            cpu_hold_d   = 1'b1;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    // Idle gap inside a frame: count cycles without an accepted byte.
    idle_cnt_d = 32'd0;
    if ((state == LEN0 || state == LEN1 || state == DATA || state == CHECK) && !accept) begin
      if (idle_cnt + 32'd1 >= 32'(TIMEOUT)) begin
        state_d      = ERROR;
        load_error_d = 1'b1;
        cpu_hold_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt + 32'd1;
      end
    end
`endif
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_lo     <= 8'h00;
      n_words    <= 16'd0;
      word_idx   <= 16'd0;
      lane       <= 2'd0;
      asm_q      <= 24'd0;
      checksum   <= 8'h00;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt   <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      len_lo     <= len_lo_d;
      n_words    <= n_words_d;
      word_idx   <= word_idx_d;
      lane       <= lane_d;
      asm_q      <= asm_d;
      checksum   <= checksum_d;
      in_ready   <= 1'b1;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_hold   <= cpu_hold_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt   <= idle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed frames plus random
// frames; expected writes go into a scoreboard queue that a negedge monitor
// drains whenever mem_we is seen.
module tb_instruction_loader;

  localparam int BUS = 32;
  localparam int MEMSIZE = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic           mem_we;
  logic [BUS-1:0] mem_addr;
  logic [BUS-1:0] mem_wdata;
  logic           cpu_hold;
  logic           load_done;
  logic           load_error;

  instruction_loader #(.bus(BUS), .memsize(MEMSIZE), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [7:0] d[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      we_prev = 1'b0;
    end else begin
      if (mem_we) begin
        check("we_single_cycle", 32'(we_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      check("in_ready", 32'(in_ready), 32'd1);
      we_prev = mem_we;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] acc = 8'h00;
    foreach (q[i]) acc = acc + q[i];
    return acc;
  endfunction

  // Reference model: word i is bytes 4i..4i+3 little-endian at byte address
  // 4i; the load succeeds iff the trailing byte equals the data-byte sum.
  task automatic send_frame(input logic [7:0] q[$], input int n, input logic [7:0] chk,
                            input bit gaps);
    wr_t w;
    bit  ok;
    for (int i = 0; i < n; i++) begin
      w.addr = 32'(i * 4);
      w.data = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
      exp_q.push_back(w);
    end
    ok = (chk == sum8(q));
    send_byte(8'hA5);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("done_cleared", 32'(load_done), 32'd0);
    check("error_cleared", 32'(load_error), 32'd0);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    foreach (q[i]) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(q[i]);
    end
    if (gaps) idle($urandom_range(0, 2));
    send_byte(chk);
    check("load_done", 32'(load_done), 32'(ok));
    check("load_error", 32'(load_error), 32'(!ok));
    check("cpu_hold_end", 32'(cpu_hold), 32'(!ok));
    idle(2);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_two_word();
    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    int n;
    logic [7:0] junk;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Good two-word load; data-byte sum is 0x64.
    fill_two_word();
    send_frame(d, 2, 8'h64, 1'b0);

    // Bad checksum, then recovery with a good frame.
    send_frame(d, 2, 8'h5D, 1'b0);
    send_frame(d, 2, 8'h64, 1'b1);

    // Junk bytes outside a frame leave state and flags unchanged.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    check("junk_keeps_done", 32'(load_done), 32'd1);
    check("junk_keeps_hold", 32'(cpu_hold), 32'd0);
    d.delete();
    send_frame(d, 0, 8'h00, 1'b0);

    // Oversize count 0x1001 is rejected; following bytes are ignored.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    check("oversize_error", 32'(load_error), 32'd1);
    check("oversize_hold", 32'(cpu_hold), 32'd1);
    check("oversize_done", 32'(load_done), 32'd0);
    foreach (d[i]) send_byte(d[i]);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    idle(2);
    check("oversize_still_error", 32'(load_error), 32'd1);

    // Count exactly equal to memsize is accepted and fills every word.
    d.delete();
    for (int i = 0; i < 4 * MEMSIZE; i++) d.push_back(8'($urandom));
    send_frame(d, MEMSIZE, sum8(d), 1'b0);

    // Reset in the middle of a frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    #1;
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_load_error", 32'(load_error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(d, 1, 8'h0E, 1'b0);

    // Idle gap inside a frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(20);
`ifdef LOADER_TIMEOUT_EN
    check("timeout_error", 32'(load_error), 32'd1);
    check("timeout_hold", 32'(cpu_hold), 32'd1);
    check("timeout_done", 32'(load_done), 32'd0);
`else
    check("wait_no_error", 32'(load_error), 32'd0);
    check("wait_hold", 32'(cpu_hold), 32'd1);
    exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'hAA);
    check("wait_resume_done", 32'(load_done), 32'd1);
    check("wait_resume_hold", 32'(cpu_hold), 32'd0);
`endif
    idle(2);
    check("gap_writes", 32'(exp_q.size()), 32'd0);

    // Randomized frames with junk prefixes, gaps and occasional bad checksums.
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      n = $urandom_range(1, 8);
      d.delete();
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      if ($urandom_range(0, 9) < 7) send_frame(d, n, sum8(d), 1'b1);
      else send_frame(d, n, sum8(d) + 8'($urandom_range(1, 255)), 1'b1);
    end

    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
